// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register-slave slice.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic {S_IDLE, S_ACCESS} apb_slv_state_t;

    function automatic logic word_aligned(input logic [APB_ADDR_W-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/apb_slave_regs_if.sv
// APB bus bundle between a master and a completer.
interface apb_slave_regs_if;
    import apb_pkg::*;

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [APB_ADDR_W-1:0] paddr;
    logic [APB_DATA_W-1:0] pwdata;
    logic [APB_DATA_W-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_slave_regfile.sv
// Register file: NUM_REGS-1 read/write words plus a live read-only STATUS word at the top index.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [APB_DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]      ridx,
    output logic [APB_DATA_W-1:0] rdata,
    input  logic [APB_DATA_W-1:0] status_in,
    output logic [APB_DATA_W-1:0] ctrl_out
);

    localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_REGS - 1);

    logic [APB_DATA_W-1:0] regs_q [NUM_REGS-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (widx != STATUS_IDX)) begin
            regs_q[widx] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        if (ridx == STATUS_IDX) begin
            rdata = status_in;
        end else begin
            rdata = regs_q[ridx];
        end
    end

    assign ctrl_out = regs_q[0];

endmodule

// File: rtl/apb_slave_regs.sv
// APB completer: SETUP/ACCESS FSM with programmable wait states, decode/error latch and register file.
module apb_slave_regs
    import apb_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                  pclk,
    input  logic                  preset,
    apb_slave_regs_if.slave       apb,
    input  logic [APB_DATA_W-1:0] status_in,
    output logic [APB_DATA_W-1:0] ctrl_out
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);
    localparam int unsigned CNT_W = 4;

    apb_slv_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             err_q, err_d;
    logic             wr_q, wr_d;

    logic [IDX_W-1:0]      dec_idx;
    logic                  dec_err;
    logic                  done;
    logic                  we;
    logic [APB_DATA_W-1:0] rdata;

    // Decode is evaluated every cycle but only captured on the SETUP transition.
    assign dec_idx = apb.paddr[2 +: IDX_W];
    assign dec_err = !word_aligned(apb.paddr)
                   | (apb.paddr >= APB_ADDR_W'(4 * NUM_REGS))
                   | (apb.pwrite & (dec_idx == IDX_W'(NUM_REGS - 1)));

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        err_d   = err_q;
        wr_d    = wr_q;
        done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (apb.psel && !apb.penable) begin
                    state_d = S_ACCESS;
                    idx_d   = dec_idx;
                    err_d   = dec_err;
                    wr_d    = apb.pwrite;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                end
            end
            S_ACCESS: begin
                if (!apb.psel) begin
                    state_d = S_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (apb.penable) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign we          = done & wr_q & !err_q;
    assign apb.pready  = done;
    assign apb.pslverr = done & err_q;
    assign apb.prdata  = (done && !wr_q && !err_q) ? rdata : '0;

    apb_slave_regfile #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk       (pclk),
        .rst       (preset),
        .we        (we),
        .widx      (idx_q),
        .wdata     (apb.pwdata),
        .ridx      (idx_q),
        .rdata     (rdata),
        .status_in (status_in),
        .ctrl_out  (ctrl_out)
    );

endmodule

// File: tb/tb_apb_slave_regs.sv
// Bench for apb_slave_regs: one DUT with one wait state, one with zero, checked each cycle against a transfer-level model.
module tb_apb_slave_regs;
    import apb_pkg::*;

    localparam int unsigned N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        preset;
    logic [31:0] status_in;
    logic [31:0] ctrl_a, ctrl_b;

    apb_slave_regs_if bus_a();
    apb_slave_regs_if bus_b();

    apb_slave_regs #(.NUM_REGS(N), .WAIT_CYCLES(1)) dut_a (
        .pclk(clk), .preset(preset), .apb(bus_a.slave), .status_in(status_in), .ctrl_out(ctrl_a)
    );
    apb_slave_regs #(.NUM_REGS(N), .WAIT_CYCLES(0)) dut_b (
        .pclk(clk), .preset(preset), .apb(bus_b.slave), .status_in(status_in), .ctrl_out(ctrl_b)
    );

    // Master-side drive, steered to whichever DUT is active in this phase.
    int          phase;
    logic        m_psel, m_penable, m_pwrite;
    logic [31:0] m_paddr, m_pwdata;

    assign bus_a.psel    = (phase == 0) ? m_psel    : 1'b0;
    assign bus_a.penable = (phase == 0) ? m_penable : 1'b0;
    assign bus_a.pwrite  = m_pwrite;
    assign bus_a.paddr   = m_paddr;
    assign bus_a.pwdata  = m_pwdata;
    assign bus_b.psel    = (phase == 1) ? m_psel    : 1'b0;
    assign bus_b.penable = (phase == 1) ? m_penable : 1'b0;
    assign bus_b.pwrite  = m_pwrite;
    assign bus_b.paddr   = m_paddr;
    assign bus_b.pwdata  = m_pwdata;

    logic        r_pready, r_pslverr;
    logic [31:0] r_prdata, r_ctrl;
    assign r_pready  = (phase == 1) ? bus_b.pready  : bus_a.pready;
    assign r_pslverr = (phase == 1) ? bus_b.pslverr : bus_a.pslverr;
    assign r_prdata  = (phase == 1) ? bus_b.prdata  : bus_a.prdata;
    assign r_ctrl    = (phase == 1) ? ctrl_b        : ctrl_a;

    // Model: register contents per DUT plus the expected response for the current cycle.
    logic [31:0] mdl [2][N];
    bit          chk_en;
    logic        exp_pready, exp_pslverr;
    logic [31:0] exp_prdata;
    logic [31:0] cap_prdata;
    logic        cap_err;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pready",   32'(r_pready),  32'(exp_pready));
            chk("pslverr",  32'(r_pslverr), 32'(exp_pslverr));
            chk("prdata",   r_prdata,       exp_prdata);
            chk("ctrl_out", r_ctrl,         mdl[phase][0]);
            if (r_pready) begin
                cap_prdata = r_prdata;
                cap_err    = r_pslverr;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic rdy, input logic err, input logic [31:0] d);
        exp_pready  = rdy;
        exp_pslverr = err;
        exp_prdata  = d;
    endtask

    task automatic clear_model();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < int'(N); i++)
                mdl[p][i] = '0;
    endtask

    function automatic bit exp_err(input bit wr, input logic [31:0] a);
        return (a % 4 != 0) || (a >= 4 * N) || (wr && (a / 4 == N - 1));
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            m_psel    = ($urandom_range(0, 3) == 0);
            m_penable = m_psel ? 1'b1 : 1'($urandom_range(0, 1));
            m_pwrite  = 1'($urandom_range(0, 1));
            m_paddr   = $urandom;
            m_pwdata  = $urandom;
            set_exp(1'b0, 1'b0, '0);
            cyc();
        end
    endtask

    // One transfer; abort_at = access-cycle index at which psel drops (-1: never).
    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input int abort_at, input bit rst_mid);
        int          w;
        bit          e;
        logic [31:0] rd;
        w = (phase == 0) ? 1 : 0;
        e = exp_err(wr, a);
        m_psel = 1'b1; m_penable = 1'b0; m_pwrite = wr; m_paddr = a; m_pwdata = $urandom;
        set_exp(1'b0, 1'b0, '0);
        cyc();
        for (int k = 0; k <= w; k++) begin
            m_penable = 1'b1;
            m_paddr   = $urandom;
            m_pwrite  = 1'($urandom_range(0, 1));
            if (rst_mid) begin
                m_pwdata = wd;
                preset   = 1'b1;
                chk_en   = 1'b0;
                cyc();
                preset = 1'b0;
                clear_model();
                m_psel = 1'b0; m_penable = 1'b0;
                set_exp(1'b0, 1'b0, '0);
                chk_en = 1'b1;
                return;
            end
            if (k == abort_at) begin
                m_psel    = 1'b0;
                m_penable = 1'($urandom_range(0, 1));
                set_exp(1'b0, 1'b0, '0);
                cyc();
                return;
            end
            if (k == w) begin
                m_pwdata = wd;
                rd = '0;
                if (!wr && !e) rd = (a / 4 == N - 1) ? status_in : mdl[phase][a / 4];
                set_exp(1'b1, e, rd);
                cyc();
                if (wr && !e) mdl[phase][a / 4] = wd;
            end else begin
                m_pwdata = $urandom;
                set_exp(1'b0, 1'b0, '0);
                cyc();
            end
        end
    endtask

    task automatic random_run(input int n, input bit allow_abort);
        int          r;
        logic [31:0] a;
        for (int t = 0; t < n; t++) begin
            r = int'($urandom_range(0, 9));
            if (r < 8)       a = 32'(r * 4);
            else if (r == 8) a = (4 * N) + 32'($urandom_range(0, 3) * 4) + (($urandom_range(0, 1) == 1) ? $urandom : 32'd0);
            else             a = 32'($urandom_range(0, N - 1) * 4 + $urandom_range(1, 3));
            status_in = $urandom;
            xfer(1'($urandom_range(0, 1)), a, $urandom,
                 (allow_abort && $urandom_range(0, 5) == 0) ? 0 : -1, 1'b0);
            idle(int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        phase = 0; chk_en = 1'b0; preset = 1'b1; status_in = '0;
        m_psel = 1'b0; m_penable = 1'b0; m_pwrite = 1'b0; m_paddr = '0; m_pwdata = '0;
        cap_prdata = '0; cap_err = 1'b0;
        clear_model();
        set_exp(1'b0, 1'b0, '0);
        repeat (2) cyc();
        chk_en = 1'b1;
        cyc();
        preset = 1'b0;

        xfer(1'b1, 32'h0, 32'hDEADBEEF, -1, 1'b0);
        xfer(1'b0, 32'h0, 32'h0, -1, 1'b0);
        chk("t1 read data", cap_prdata, 32'hDEADBEEF);
        chk("t1 ctrl_out", ctrl_a, 32'hDEADBEEF);

        status_in = 32'h0000A5A5;
        xfer(1'b0, 32'h1C, 32'h0, -1, 1'b0);
        chk("t2 status read", cap_prdata, 32'h0000A5A5);
        xfer(1'b1, 32'h1C, 32'h1234, -1, 1'b0);
        chk("t2 status write err", 32'(cap_err), 32'd1);
        xfer(1'b0, 32'h1C, 32'h0, -1, 1'b0);
        chk("t2 status reread", cap_prdata, 32'h0000A5A5);

        xfer(1'b1, 32'h20, 32'h11111111, -1, 1'b0);
        chk("t3 range err", 32'(cap_err), 32'd1);
        xfer(1'b1, 32'h06, 32'h22222222, -1, 1'b0);
        chk("t3 unaligned err", 32'(cap_err), 32'd1);
        chk("t3 ctrl kept", ctrl_a, 32'hDEADBEEF);

        xfer(1'b1, 32'h4, 32'h55, 0, 1'b0);
        idle(1);
        xfer(1'b0, 32'h4, 32'h0, -1, 1'b0);
        chk("t4 aborted write", cap_prdata, 32'h0);

        xfer(1'b1, 32'h4, 32'hFF, -1, 1'b1);
        chk("t6 ctrl after reset", ctrl_a, 32'h0);
        idle(1);
        xfer(1'b0, 32'h4, 32'h0, -1, 1'b0);
        chk("t6 reg1 after reset", cap_prdata, 32'h0);

        random_run(150, 1'b1);

        m_psel = 1'b0; m_penable = 1'b0;
        phase = 1;
        idle(1);
        xfer(1'b1, 32'h8, 32'hCAFEF00D, -1, 1'b0);
        xfer(1'b0, 32'h8, 32'h0, -1, 1'b0);
        chk("t5 back-to-back read", cap_prdata, 32'hCAFEF00D);

        random_run(150, 1'b0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
